// File: rtl/morse_sender.sv
// Morse-code transmitter for A-Z: latches a letter on start, plays dots/dashes
// with parametrised durations and gaps, optional character repeat.
module morse_sender #(
  parameter int unsigned DOT_TICKS      = 1,
  parameter int unsigned DASH_TICKS     = 3,
  parameter int unsigned GAP_TICKS      = 1,
  parameter int unsigned CHAR_GAP_TICKS = 3
) (
  input  logic       half_sec,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] letter_in,
  input  logic       repeat_char,
  output logic       light,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] state
);

  localparam int unsigned MAX_SYM = (DOT_TICKS > DASH_TICKS) ? DOT_TICKS : DASH_TICKS;
  localparam int unsigned MAX_GAP = (GAP_TICKS > CHAR_GAP_TICKS) ? GAP_TICKS : CHAR_GAP_TICKS;
  localparam int unsigned MAX_T   = (MAX_SYM > MAX_GAP) ? MAX_SYM : MAX_GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_T + 1);
  localparam int unsigned PAT_W   = 4;
  localparam int unsigned LEN_W   = 3;

  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_TICKS - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CG_LD   = CNT_W'(CHAR_GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MARK     = 2'd1,
    S_SPACE    = 2'd2,
    S_CHAR_GAP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [PAT_W-1:0]   lat_pat_q, lat_pat_d;
  logic [LEN_W-1:0]   lat_len_q, lat_len_d;
  logic               done_d, err_d;

  logic [PAT_W-1:0]   rom_pat;
  logic [LEN_W-1:0]   rom_len;
  logic               rom_valid;

  // Letter ROM: pattern bit 0 is the first symbol, 1 = dash
  always_comb begin
    rom_pat   = '0;
    rom_len   = '0;
    rom_valid = 1'b1;
    case (letter_in)
      5'd0:  begin rom_pat = 4'b0010; rom_len = 3'd2; end // A .-
      5'd1:  begin rom_pat = 4'b0001; rom_len = 3'd4; end // B -...
      5'd2:  begin rom_pat = 4'b0101; rom_len = 3'd4; end // C -.-.
      5'd3:  begin rom_pat = 4'b0001; rom_len = 3'd3; end // D -..
      5'd4:  begin rom_pat = 4'b0000; rom_len = 3'd1; end // E .
      5'd5:  begin rom_pat = 4'b0100; rom_len = 3'd4; end // F ..-.
      5'd6:  begin rom_pat = 4'b0011; rom_len = 3'd3; end // G --.
      5'd7:  begin rom_pat = 4'b0000; rom_len = 3'd4; end // H ....
      5'd8:  begin rom_pat = 4'b0000; rom_len = 3'd2; end // I ..
      5'd9:  begin rom_pat = 4'b1110; rom_len = 3'd4; end // J .---
      5'd10: begin rom_pat = 4'b0101; rom_len = 3'd3; end // K -.-
      5'd11: begin rom_pat = 4'b0010; rom_len = 3'd4; end // L .-..
      5'd12: begin rom_pat = 4'b0011; rom_len = 3'd2; end // M --
      5'd13: begin rom_pat = 4'b0001; rom_len = 3'd2; end // N -.
      5'd14: begin rom_pat = 4'b0111; rom_len = 3'd3; end // O ---
      5'd15: begin rom_pat = 4'b0110; rom_len = 3'd4; end // P .--.
      5'd16: begin rom_pat = 4'b1011; rom_len = 3'd4; end // Q --.-
      5'd17: begin rom_pat = 4'b0010; rom_len = 3'd3; end // R .-.
      5'd18: begin rom_pat = 4'b0000; rom_len = 3'd3; end // S ...
      5'd19: begin rom_pat = 4'b0001; rom_len = 3'd1; end // T -
      5'd20: begin rom_pat = 4'b0100; rom_len = 3'd3; end // U ..-
      5'd21: begin rom_pat = 4'b1000; rom_len = 3'd4; end // V ...-
      5'd22: begin rom_pat = 4'b0110; rom_len = 3'd3; end // W .--
      5'd23: begin rom_pat = 4'b1001; rom_len = 3'd4; end // X -..-
      5'd24: begin rom_pat = 4'b1101; rom_len = 3'd4; end // Y -.--
      5'd25: begin rom_pat = 4'b0011; rom_len = 3'd4; end // Z --..
      default: rom_valid = 1'b0;
    endcase
  end

  // Next-state, counters and pulse outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    rem_d     = rem_q;
    lat_pat_d = lat_pat_q;
    lat_len_d = lat_len_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (rom_valid) begin
            lat_pat_d = rom_pat;
            lat_len_d = rom_len;
            pat_d     = rom_pat;
            rem_d     = rom_len;
            cnt_d     = rom_pat[0] ? DASH_LD : DOT_LD;
            state_d   = S_MARK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (cnt_q == '0) begin
          pat_d = pat_q >> 1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q > LEN_W'(1)) begin
            cnt_d   = GAP_LD;
            state_d = S_SPACE;
          end else begin
            cnt_d   = CG_LD;
            state_d = S_CHAR_GAP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SPACE: begin
        if (cnt_q == '0) begin
          cnt_d   = pat_q[0] ? DASH_LD : DOT_LD;
          state_d = S_MARK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHAR_GAP: begin
        if (cnt_q == '0) begin
          if (repeat_char) begin
            pat_d   = lat_pat_q;
            rem_d   = lat_len_q;
            cnt_d   = lat_pat_q[0] ? DASH_LD : DOT_LD;
            state_d = S_MARK;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge half_sec or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pat_q     <= '0;
      rem_q     <= '0;
      lat_pat_q <= '0;
      lat_len_q <= '0;
      light     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      rem_q     <= rem_d;
      lat_pat_q <= lat_pat_d;
      lat_len_q <= lat_len_d;
      light     <= (state_d == S_MARK);
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      err       <= err_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_morse_sender.sv
// Directed bench for morse_sender: expected light/state per cycle are built
// from a textual Morse table into a scoreboard queue and popped each cycle.
module tb_morse_sender;

  logic       half_sec = 1'b0;
  logic       reset, start, start_q, repeat_char;
  logic [4:0] letter_in;
  logic       light_a, busy_a, done_a, err_a;
  logic [1:0] state_a;
  logic       light_q, busy_q, done_q, err_q;
  logic [1:0] state_q;

  int checks   = 0;
  int failures = 0;

  bit         exp_light[$];
  logic [1:0] exp_state[$];

  string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--.."};

  morse_sender dut_a (
    .half_sec(half_sec), .reset(reset), .start(start), .letter_in(letter_in),
    .repeat_char(repeat_char), .light(light_a), .busy(busy_a), .done(done_a),
    .err(err_a), .state(state_a)
  );

  morse_sender #(.DOT_TICKS(2), .DASH_TICKS(5), .GAP_TICKS(2), .CHAR_GAP_TICKS(6)) dut_q (
    .half_sec(half_sec), .reset(reset), .start(start_q), .letter_in(letter_in),
    .repeat_char(repeat_char), .light(light_q), .busy(busy_q), .done(done_q),
    .err(err_q), .state(state_q)
  );

  always #5 half_sec = ~half_sec;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {light, busy, done, err, state} of the selected instance
  function automatic logic [5:0] outs(input int sel);
    if (sel == 1) return {light_q, busy_q, done_q, err_q, state_q};
    return {light_a, busy_a, done_a, err_a, state_a};
  endfunction

  task automatic push_char(input int letter, input int dot, input int dash,
                           input int gap, input int cg);
    string code;
    int d;
    code = morse[letter];
    for (int s = 0; s < code.len(); s++) begin
      d = (code[s] == "-") ? dash : dot;
      repeat (d) begin exp_light.push_back(1'b1); exp_state.push_back(2'd1); end
      if (s < code.len() - 1)
        repeat (gap) begin exp_light.push_back(1'b0); exp_state.push_back(2'd2); end
    end
    repeat (cg) begin exp_light.push_back(1'b0); exp_state.push_back(2'd3); end
  endtask

  // Pop one expectation per cycle; optional start drop, mid-character start
  // injection, repeat drop, and early stop after n_limit cycles.
  task automatic play_check(input int sel, input int keep_start, input int inj,
                            input int rpt_drop, input int n_limit);
    int n;
    logic [5:0] o;
    bit el;
    logic [1:0] es;
    n = exp_light.size();
    if (n_limit > 0 && n_limit < n) n = n_limit;
    for (int i = 1; i <= n; i++) begin
      @(negedge half_sec);
      el = exp_light.pop_front();
      es = exp_state.pop_front();
      o  = outs(sel);
      check($sformatf("light[%0d]", i), 8'(o[5]), 8'(el));
      check($sformatf("busy[%0d]",  i), 8'(o[4]), 8'd1);
      check($sformatf("done[%0d]",  i), 8'(o[3]), 8'd0);
      check($sformatf("err[%0d]",   i), 8'(o[2]), 8'd0);
      check($sformatf("state[%0d]", i), 8'(o[1:0]), 8'(es));
      if (i == 1 && keep_start == 0) begin start = 1'b0; start_q = 1'b0; end
      if (inj > 0 && i == inj)     begin start = 1'b1; letter_in = 5'd14; end
      if (inj > 0 && i == inj + 2) start = 1'b0;
      if (i == rpt_drop) repeat_char = 1'b0;
    end
  endtask

  task automatic check_done(input int sel, input string tag);
    logic [5:0] o;
    @(negedge half_sec);
    o = outs(sel);
    check({tag, "_done"},  8'(o[3]), 8'd1);
    check({tag, "_busy"},  8'(o[4]), 8'd0);
    check({tag, "_light"}, 8'(o[5]), 8'd0);
    check({tag, "_state"}, 8'(o[1:0]), 8'd0);
  endtask

  task automatic check_idle(input int sel, input string tag);
    logic [5:0] o;
    @(negedge half_sec);
    o = outs(sel);
    check({tag, "_idle_done"}, 8'(o[3]), 8'd0);
    check({tag, "_idle_busy"}, 8'(o[4]), 8'd0);
    check({tag, "_idle_light"}, 8'(o[5]), 8'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start_q = 1'b0; repeat_char = 1'b0; letter_in = 5'd0;
    repeat (3) @(negedge half_sec);
    check("rst_a", 8'(outs(0)), 8'd0);
    check("rst_q", 8'(outs(1)), 8'd0);
    reset = 1'b1;
    @(negedge half_sec);

    // Letter A, single-edge start
    start = 1'b1; letter_in = 5'd0;
    push_char(0, 1, 3, 1, 3);
    check("a_len", 8'(exp_light.size()), 8'd8);
    play_check(0, 0, -1, -1, 0);
    check_done(0, "a");
    check_idle(0, "a");

    // E then T with start held high throughout E
    start = 1'b1; letter_in = 5'd4;
    push_char(4, 1, 3, 1, 3);
    play_check(0, 1, -1, -1, 0);
    letter_in = 5'd19;
    check_done(0, "e");
    push_char(19, 1, 3, 1, 3);
    play_check(0, 0, -1, -1, 0);
    check_done(0, "t");
    check_idle(0, "t");

    // Invalid letter raises err only
    start = 1'b1; letter_in = 5'd27;
    @(negedge half_sec);
    check("inv_err",   8'(err_a),   8'd1);
    check("inv_busy",  8'(busy_a),  8'd0);
    check("inv_light", 8'(light_a), 8'd0);
    check("inv_state", 8'(state_a), 8'd0);
    start = 1'b0;
    @(negedge half_sec);
    check("inv_err_clr", 8'(err_a), 8'd0);

    // A with a start for O injected while busy
    start = 1'b1; letter_in = 5'd0;
    push_char(0, 1, 3, 1, 3);
    play_check(0, 0, 3, -1, 0);
    check_done(0, "a_inj");
    check_idle(0, "a_inj");

    // T with repeat, letter changed mid-character, repeat dropped in second MARK
    repeat_char = 1'b1; start = 1'b1; letter_in = 5'd19;
    push_char(19, 1, 3, 1, 3);
    push_char(19, 1, 3, 1, 3);
    play_check(0, 0, 3, 8, 0);
    check_done(0, "rpt");
    check_idle(0, "rpt");

    // Reset asserted during SPACE of O
    start = 1'b1; letter_in = 5'd14;
    push_char(14, 1, 3, 1, 3);
    play_check(0, 0, -1, -1, 4);
    reset = 1'b0;
    #1;
    check("arst_light", 8'(light_a), 8'd0);
    check("arst_busy",  8'(busy_a),  8'd0);
    check("arst_state", 8'(state_a), 8'd0);
    check("arst_done",  8'(done_a),  8'd0);
    exp_light.delete();
    exp_state.delete();
    @(negedge half_sec);
    check("arst_hold_done", 8'(done_a), 8'd0);
    reset = 1'b1; start = 1'b1; letter_in = 5'd0;
    push_char(0, 1, 3, 1, 3);
    play_check(0, 0, -1, -1, 0);
    check_done(0, "a_post_rst");

    // Q on the long-timing instance
    start_q = 1'b1; letter_in = 5'd16;
    push_char(16, 2, 5, 2, 6);
    check("q_len", 8'(exp_light.size()), 8'd29);
    play_check(1, 0, -1, -1, 0);
    check_done(1, "q");
    check_idle(1, "q");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_sender.md
# morse_sender

Parametrised Morse-code transmitter for the full A–Z alphabet, driving a single light output from the `half_sec` time base. It latches a 5-bit letter code on a `start` request and plays dots and dashes with configurable durations. It also inserts inter-symbol and end-of-character gaps, reports busy/done/error status, and can optionally repeat the character. It is the next-generation replacement for the 3-bit, fixed-timing encoder/counter/shift-register/FSM chain under the morse_code top.

## Interface
- `DOT_TICKS`, default 1: light-on cycles for a dot (≥1)
- `DASH_TICKS`, default 3: light-on cycles for a dash (≥1)
- `GAP_TICKS`, default 1: light-off cycles between symbols of one letter (≥1)
- `CHAR_GAP_TICKS`, default 3: light-off cycles after the last symbol (≥1)
- `half_sec`  in  1  clock, all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request to send `letter_in`, sampled each edge
- `letter_in`  in  5  letter code, 0 = A … 25 = Z; 26–31 invalid
- `repeat`  in  1  when high at the end of CHAR_GAP, replay the latched letter
- `light`  out  1  Morse output, high during a symbol
- `busy`  out  1  high from accept until return to IDLE
- `done`  out  1  one-cycle pulse when a character (incl. CHAR_GAP) completes without repeat
- `err`  out  1  one-cycle pulse when `start` arrives in IDLE with invalid `letter_in`
- `state`  out  2  debug: 0 IDLE, 1 MARK, 2 SPACE, 3 CHAR_GAP

## Operation
- Internal ROM, combinational on `letter_in`: standard International Morse, length 1–4, pattern bits LSB-first, 1 = dash. Examples: E = `.` (len 1), T = `-`, A = `.-`, O = `---`, Q = `--.-`, Y = `-.--`.
- Tick counter width is clog2(max(all four parameters)+1). It is loaded with duration−1 on entry to a state. A state exits on the edge where the counter equals 0.
- IDLE:
  - `start` with a valid letter latches the pattern into a 4-bit shift register and the length into a 3-bit remaining counter, then goes to MARK.
  - `start` with an invalid letter pulses `err` and stays in IDLE.
- MARK: `light`=1. Duration is DASH_TICKS if the pattern LSB is 1, else DOT_TICKS. On exit, shift the pattern right and decrement remaining. Go to SPACE if remaining is still >0, otherwise to CHAR_GAP.
- SPACE: `light`=0 for GAP_TICKS cycles, then MARK.
- CHAR_GAP: `light`=0 for CHAR_GAP_TICKS cycles. On exit:
  - `repeat`=1: reload the pattern and length from the latched letter and go to MARK; no `done`.
  - Otherwise: go to IDLE and pulse `done`.
- `start` is ignored while `busy`=1. No queuing, no `err`.
- `letter_in` is only sampled at accept. Later changes have no effect, including on repeats.
- Dropping `repeat` mid-character takes effect at the next CHAR_GAP exit.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, `light`=0, `busy`=0, `done`=0, `err`=0, counters and shift register 0. Asserting reset mid-character aborts immediately, with no `done`. The first accept is possible on the first edge after release.
- All outputs are registered.
- Accept at edge k: `light`=1 and `busy`=1 from edge k.
- `done` is high for exactly the cycle after the final CHAR_GAP edge. `busy` falls on that same edge.
- Busy length for one character = Σ(symbol durations) + (len−1)·GAP_TICKS + CHAR_GAP_TICKS.
- `start` held high continuously: the next letter is accepted on the edge after `done` (one IDLE cycle minimum).
- `err` is high for exactly the cycle after the offending edge.

## Test plan
- Defaults, letter A (0), one-edge `start` -> `light` per cycle is 1,0,1,1,1,0,0,0; `busy` high 8 cycles; `done` pulses once in cycle 9.
- Defaults, letter E (4) then T (19) with `start` held high -> E gives `light` 1,0,0,0, then `done`, then one IDLE cycle; T gives 1,1,1,0,0,0.
- DOT=2, DASH=5, GAP=2, CHAR_GAP=6, letter Q (16) -> `light` high 5, low 2, high 5, low 2, high 2, low 2, high 5, low 6; busy = 29 cycles.
- `letter_in`=27 with `start` -> `err` one cycle, `busy` stays 0, `light` stays 0. Then `start` during A with `letter_in`=14 is ignored: A completes unchanged.
- `repeat`=1 with letter T -> pattern 1,1,1,0,0,0 repeats with no `done`. Drop `repeat` in the second MARK -> `done` after the second CHAR_GAP.
- Reset pulsed in the SPACE of letter O (14) -> `light`=0, `busy`=0 immediately, no `done`. After release, `start` with A plays the full A sequence.
